// File: rtl/demux_1to16_dispatch.sv
// demux_1to16_dispatch: dispatches one word per cycle into one of 16 one-entry holding registers. Data appears 1 cycle after accept.
// Backpressure: in_ready follows the target channel's free state, with no bubble on drain+reload. DEMUX_BROADCAST_EN enables in_bcast.
module demux_1to16_dispatch #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [3:0]            in_sel,
  input  logic                  in_bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [16*WIDTH-1:0]   out_data,
  output logic [15:0]           out_valid,
  input  logic [15:0]           out_ready
);

  logic [15:0]            free;
  logic [15:0]            load;
  logic                   accept;
  logic [15:0][WIDTH-1:0] hold_data;

  // A full channel whose consumer takes its word this cycle can be refilled in the same cycle.
  assign free = ~out_valid | out_ready;

`ifdef DEMUX_BROADCAST_EN
  assign in_ready = in_bcast ? (&free) : free[in_sel];
  assign accept   = in_valid & in_ready;
  assign load     = !accept  ? 16'h0000 :
                    in_bcast ? 16'hFFFF : (16'h0001 << in_sel);
`else
  logic unused_bcast;
  assign unused_bcast = in_bcast;
  assign in_ready     = free[in_sel];
  assign accept       = in_valid & in_ready;
  assign load         = accept ? (16'h0001 << in_sel) : 16'h0000;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_valid <= '0;
      hold_data <= '0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (load[k]) begin
          out_valid[k] <= 1'b1;
          hold_data[k] <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign out_data = hold_data;

endmodule

// File: doc/demux_1to16_dispatch.md
Name: demux_1to16_dispatch

Overview:
- Sequential 1-to-16 demultiplexer: the write-side counterpart of the 16-to-1 select path in the datapath.
- Accepts one WIDTH-bit word per cycle on a valid/ready input, with a 4-bit destination select.
- Delivers the word into a one-entry holding register for the selected channel. Each of the 16 channels drains independently on its own valid/ready output.
- Sits between the ALU result bus and downstream per-channel consumers (register write ports, output latches).

Parameters:
WIDTH, 32, data width of the input word and of each output channel.

Ports:
clk  input  1  rising-edge clock.
rstb  input  1  asynchronous active-low reset.
in_data  input  WIDTH  word to dispatch.
in_sel  input  4  destination channel index, 0..15.
in_bcast  input  1  broadcast request (used only with the optional feature).
in_valid  input  1  in_data/in_sel/in_bcast valid.
in_ready  output  1  block can accept this cycle.
out_data  output  16*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
out_valid  output  16  per-channel holding register full.
out_ready  input  16  per-channel consumer ready.

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-low on rstb; reset is asserted while rstb=0.
- Reset values: all out_valid=0 and all out_data=0.
  - in_ready is combinational. During reset it evaluates with all channels empty, so it reads 1.
- Per-channel state (two-state, no separate FSM register):
  - EMPTY (out_valid[k]=0).
  - FULL (out_valid[k]=1).
- Channel k is free this cycle when out_valid[k]=0 or out_ready[k]=1. A full channel being drained counts as free.
- in_ready = free[in_sel]. It is purely combinational, with no dependency on in_valid.
- Accept = in_valid & in_ready. On accept at edge N, channel in_sel loads in_data and out_valid[in_sel]=1 after edge N.
  - Latency: 1 cycle from accept to out_valid.
  - Throughput: 1 word per cycle to any channel, including back-to-back to the same channel if its consumer holds out_ready=1.
- Drain: when out_valid[k]&out_ready[k] and there is no simultaneous load to k, out_valid[k] clears at the edge.
- Drain and load to the same channel in the same cycle: channel stays FULL with the new data, with no bubble.
- Other channels are unaffected by an accept. All 16 channels may drain in the same cycle.
- When not reloaded, out_data[k] holds its last value after draining. Consumers must qualify it with out_valid[k].
- FULL-channel stall: in_valid=1 to a full channel with out_ready=0 gives in_ready=0. in_data, in_sel and in_bcast must stay stable until accept; the block does not check this.
- Reset mid-operation: all channels go to EMPTY immediately (asynchronously) and any pending words are discarded.

Optional Feature:
- Macro: DEMUX_BROADCAST_EN.
- With the macro defined:
  - When in_bcast=1, in_sel is ignored.
  - in_ready = AND of free[0..15].
  - On accept, all 16 channels load in_data and set out_valid together.
  - When in_bcast=0, behaviour is unchanged.
- Without the macro: the in_bcast port exists but is ignored, and all transfers are unicast.

Test Plan:
1. Reset: hold rstb=0 with random inputs -> out_valid=16'h0000, all out_data=0, in_ready=1. Release rstb, drive in_valid=1, in_sel=5, in_data=32'hDEADBEEF -> next cycle out_valid=16'h0020 and channel 5 = DEADBEEF.
2. Stall: channel 5 full, out_ready[5]=0, send sel=5 data 32'h12345678 -> in_ready=0 and channel 5 keeps DEADBEEF. Raise out_ready[5] -> accept that cycle; channel 5 = 12345678 next cycle and out_valid[5] stays 1 (no bubble).
3. Streaming: out_ready=16'hFFFF, send 16 consecutive words sel=0..15 with data=sel*3 -> each out_valid[k] is high exactly one cycle, at cycle k+1, carrying value 3k. in_ready is 1 throughout.
4. Independence: channels 2 and 9 full and stalled, send sel=4 data 32'hA5A5A5A5 -> accepted; channels 2 and 9 unchanged; out_valid=16'h0214.
5. Async reset mid-stream: drop rstb between clock edges with 3 channels full -> out_valid goes to 0 immediately, without waiting for an edge.
6. Broadcast (DEMUX_BROADCAST_EN defined): channel 7 full and stalled, in_bcast=1 data 32'h0F0F0F0F -> in_ready=0. Release out_ready[7] -> accept; next cycle out_valid=16'hFFFF and all channels = 0F0F0F0F. Without the macro, the same stimulus is a unicast to in_sel.
